// File: rtl/gray_wptr_ctrl_pkg.sv
// gray_wptr_ctrl_pkg: pointer-width and full-match helpers for the gray write-pointer controller
package gray_wptr_ctrl_pkg;

    function automatic int ptr_width(input int ptr_w);
        return ptr_w + 1;
    endfunction

    // Gray pointers are a full FIFO apart when their top two bits differ and the rest match.
    function automatic logic [31:0] full_mask(input int ptr_w);
        return 32'd3 << (ptr_w - 1);
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// bin_to_gray: binary to reflected gray code conversion
module bin_to_gray #(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] bin_i,
    output logic [CNT_W-1:0] gray_o
);
    assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/gray_to_bin.sv
// gray_to_bin: reflected gray code to binary conversion
module gray_to_bin #(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] gray_i,
    output logic [CNT_W-1:0] bin_o
);
    for (genvar g = 0; g < CNT_W; g++) begin : g_bit
        assign bin_o[g] = ^gray_i[CNT_W-1:g];
    end
endmodule

// File: rtl/gray_wptr_ctrl.sv
// gray_wptr_ctrl: write-side pointer controller for a gray-pointer FIFO
// Keeps the binary write pointer, exports a registered gray copy, and derives full/level/error flags.
module gray_wptr_ctrl
    import gray_wptr_ctrl_pkg::*;
#(
    parameter int PTR_W    = 4,
    parameter int AFULL_TH = 2**PTR_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_v_i,
    input  logic [PTR_W:0]   rd_ptr_gray_i,
    output logic             wr_en_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [PTR_W:0]   wr_ptr_gray_o,
    output logic             full_o,
    output logic             afull_o,
    output logic [PTR_W:0]   level_o,
    output logic             ovf_o,
    output logic             ptr_err_o
);
    localparam int PW = ptr_width(PTR_W);
    localparam logic [PW-1:0] FULL_MASK = PW'(full_mask(PTR_W));
    localparam logic [PW-1:0] DEPTH = PW'(2**PTR_W);
    localparam logic [PW-1:0] AF_TH = PW'(AFULL_TH);

    logic [PW-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d, rd_bin;
    logic          ovf_q, ovf_d, ptr_err_q, ptr_err_d;

    gray_to_bin #(.CNT_W(PW)) u_rd_g2b (.gray_i(rd_ptr_gray_i), .bin_o(rd_bin));

    // The gray flop is fed from the converted next pointer so the exported value is glitch-free.
    bin_to_gray #(.CNT_W(PW)) u_wr_b2g (.bin_i(wr_bin_d), .gray_o(wr_gray_d));

    always_comb begin
        full_o    = (wr_gray_q == (rd_ptr_gray_i ^ FULL_MASK));
        wr_en_o   = wr_v_i & ~full_o & ~rst;
        level_o   = wr_bin_q - rd_bin;
        afull_o   = (level_o >= AF_TH);
        wr_bin_d  = wr_bin_q + {{PTR_W{1'b0}}, wr_en_o};
        ovf_d     = ovf_q | (wr_v_i & full_o);
        ptr_err_d = ptr_err_q | (level_o > DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            ovf_q     <= 1'b0;
            ptr_err_q <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            ovf_q     <= ovf_d;
            ptr_err_q <= ptr_err_d;
        end
    end

    assign wr_addr_o     = wr_bin_q[PTR_W-1:0];
    assign wr_ptr_gray_o = wr_gray_q;
    assign ovf_o         = ovf_q;
    assign ptr_err_o     = ptr_err_q;
endmodule

// File: tb/tb_gray_wptr_ctrl.sv
// tb_gray_wptr_ctrl: directed checks of the gray write-pointer controller with PTR_W=3
module tb_gray_wptr_ctrl;
    logic       clk, rst, wr_v;
    logic [3:0] rd_g;
    logic       wr_en, full, afull, ovf, ptr_err;
    logic [2:0] wr_addr;
    logic [3:0] wr_ptr_gray, level, prev_g;
    int checks = 0;
    int errors = 0;
    logic [3:0] seq [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    gray_wptr_ctrl #(.PTR_W(3)) dut (
        .clk(clk), .rst(rst), .wr_v_i(wr_v), .rd_ptr_gray_i(rd_g),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_ptr_gray_o(wr_ptr_gray),
        .full_o(full), .afull_o(afull), .level_o(level),
        .ovf_o(ovf), .ptr_err_o(ptr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_v = 1'b0; rd_g = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_gray", 32'(wr_ptr_gray), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_addr", 32'(wr_addr), 0);
        chk("rst_wren", 32'(wr_en), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_perr", 32'(ptr_err), 0);
        // fill with eight back-to-back writes
        wr_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("fill_wren", 32'(wr_en), 1);
            chk("fill_addr", 32'(wr_addr), 32'(i));
            chk("fill_level", 32'(level), 32'(i));
            chk("fill_afull", 32'(afull), 32'(i >= 6));
            prev_g = wr_ptr_gray;
            tick();
            chk("fill_gray", 32'(wr_ptr_gray), 32'(seq[i]));
            chk("fill_1bit", $countones(prev_g ^ wr_ptr_gray), 1);
        end
        chk("full_set", 32'(full), 1);
        chk("full_level", 32'(level), 8);
        chk("full_afull", 32'(afull), 1);
        chk("full_wren", 32'(wr_en), 0);
        tick();
        chk("ovf_hold_gray", 32'(wr_ptr_gray), 32'hC);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_wren", 32'(wr_en), 0);
        tick();
        chk("ovf_hold_gray2", 32'(wr_ptr_gray), 32'hC);
        wr_v = 1'b0;
        tick();
        chk("ovf_sticky", 32'(ovf), 1);
        // read pointer advance in the same cycle as a write request while full
        wr_v = 1'b1; rd_g = 4'h1;
        #1;
        chk("simul_full", 32'(full), 0);
        chk("simul_wren", 32'(wr_en), 1);
        chk("simul_addr", 32'(wr_addr), 0);
        chk("simul_level", 32'(level), 7);
        tick();
        wr_v = 1'b0;
        #1;
        chk("simul_level2", 32'(level), 8);
        chk("simul_full2", 32'(full), 1);
        chk("simul_gray", 32'(wr_ptr_gray), 32'hD);
        // reset clears sticky state
        rst = 1'b1; rd_g = 4'h0;
        #1;
        chk("rst2_ovf", 32'(ovf), 0);
        tick();
        rst = 1'b0;
        wr_v = 1'b1;
        repeat (5) tick();
        chk("mid_gray_pre", 32'(wr_ptr_gray), 32'h7);
        rst = 1'b1;
        #1;
        chk("mid_rst_gray", 32'(wr_ptr_gray), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_wren", 32'(wr_en), 0);
        tick();
        rst = 1'b0;
        // four writes, then write continuously while the read pointer follows
        repeat (4) tick();
        chk("wrap_pre_level", 32'(level), 4);
        for (int k = 0; k < 16; k++) begin
            rd_g = gtab[k];
            #1;
            chk("wrap_level", 32'(level), 4);
            chk("wrap_wren", 32'(wr_en), 1);
            chk("wrap_addr", 32'(wr_addr), 32'((k + 4) % 8));
            chk("wrap_afull", 32'(afull), 0);
            prev_g = wr_ptr_gray;
            tick();
            chk("wrap_gray", 32'(wr_ptr_gray), 32'(gtab[(k + 5) % 16]));
            chk("wrap_1bit", $countones(prev_g ^ wr_ptr_gray), 1);
        end
        chk("wrap_ovf", 32'(ovf), 0);
        // wr_bin is now 4; read pointer one ahead implies level 15
        wr_v = 1'b0; rd_g = 4'h7;
        #1;
        chk("perr_level", 32'(level), 15);
        chk("perr_pre", 32'(ptr_err), 0);
        tick();
        chk("perr_set", 32'(ptr_err), 1);
        rd_g = 4'h6;
        tick();
        chk("perr_level0", 32'(level), 0);
        chk("perr_sticky", 32'(ptr_err), 1);
        rst = 1'b1;
        #1;
        chk("perr_clear", 32'(ptr_err), 0);
        tick();
        rst = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_wptr_ctrl.md
Name: gray_wptr_ctrl

Overview:
- Write-side pointer controller for a gray-pointer FIFO. Runs entirely in the write clock domain.
- Accepts write requests and keeps the binary write pointer. Publishes a registered, glitch-free gray write pointer for export to the read domain.
- Decodes the already-synchronised gray read pointer to produce full, almost-full, fill level and error flags.
- Sequences the existing bin_to_gray / gray_to_bin converters around the FIFO storage RAM.

Parameters:
PTR_W, 4, address width; FIFO depth = 2**PTR_W; pointers are PTR_W+1 bits (extra wrap bit)
AFULL_TH, 2**PTR_W-2, level at or above which afull_o asserts; legal range 1..2**PTR_W

Ports:
clk  in  1  write-domain clock
rst  in  1  asynchronous active-high reset
wr_v_i  in  1  write request
rd_ptr_gray_i  in  PTR_W+1  read pointer, gray coded, already synchronised to clk
wr_en_o  out  1  write accepted this cycle; RAM write strobe
wr_addr_o  out  PTR_W  RAM write address
wr_ptr_gray_o  out  PTR_W+1  registered gray write pointer, exported across the clock domain
full_o  out  1  FIFO full
afull_o  out  1  level >= AFULL_TH
level_o  out  PTR_W+1  occupancy as seen from the write side, 0..2**PTR_W
ovf_o  out  1  sticky: write requested while full
ptr_err_o  out  1  sticky: decoded read pointer implies level > depth

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: wr_bin_q=0, wr_gray_q=0, ovf_o=0, ptr_err_o=0.
  - With rd_ptr_gray_i=0 this gives wr_en_o=0 (when wr_v_i=0), wr_addr_o=0, wr_ptr_gray_o=0, full_o=0, afull_o=0, level_o=0.
- Reset mid-operation: all state returns to its reset value immediately. No write is accepted while rst is high; wr_en_o is forced to 0.
- Pointer state: wr_bin_q is PTR_W+1 bits.
  - wr_gray_q is a flop that holds bin_to_gray(wr_bin_q), updated in the same edge as wr_bin_q. This is done by converting the next binary value before the flop.
  - wr_ptr_gray_o = wr_gray_q, driven straight from a flop with no combinational logic on the output.
- Accept rule: wr_en_o = wr_v_i & ~full_o & ~rst, combinational, same cycle.
  - On wr_en_o: wr_bin_q <= wr_bin_q+1, wrapping modulo 2**(PTR_W+1). Consecutive wr_ptr_gray_o values differ in exactly one bit, including at the wrap from all-ones to 0.
- Address: wr_addr_o = wr_bin_q[PTR_W-1:0]. The RAM write uses the current address; the pointer advances after the edge.
- Read-pointer decode: rd_bin = gray_to_bin(rd_ptr_gray_i), combinational.
- Level: level_o = (wr_bin_q - rd_bin) modulo 2**(PTR_W+1).
- Full: full_o = (wr_gray_q == {~rd_ptr_gray_i[PTR_W:PTR_W-1], rd_ptr_gray_i[PTR_W-2:0]}).
  - This is equivalent to level_o == 2**PTR_W. For PTR_W=1 the comparison reduces to both bits inverted.
- Almost full: afull_o = (level_o >= AFULL_TH).
- Sticky errors:
  - ovf_o sets on wr_v_i & full_o. The write is dropped and the pointer is unchanged.
  - ptr_err_o sets when level_o > 2**PTR_W, which indicates a corrupted or mis-synchronised read pointer.
  - Both flags clear only on rst.
- Simultaneous events:
  - A read-pointer advance in the same cycle as a write is seen combinationally. full_o may deassert and the write is then accepted in that same cycle.
  - Because the read pointer is delayed by synchronisation, full_o is pessimistic; this is the intended behaviour.
- Latency:
  - wr_ptr_gray_o reflects an accepted write 1 cycle after wr_en_o.
  - full_o, level_o and afull_o reflect own writes 1 cycle later, and read-pointer changes in 0 cycles.

Decomposition:
- Shared package (utils pkg): a function returning pointer width from PTR_W, and a constant helper for the full-match mask. No new typedefs are required.
- Sub-modules: reuse the existing bin_to_gray (CNT_W=PTR_W+1) on the next-pointer path and gray_to_bin (CNT_W=PTR_W+1) on the read-pointer path. No new sub-module.

Test Plan:
- PTR_W=3, reset then rd_ptr_gray_i=0 -> all outputs 0. Assert rst mid-stream after 5 writes -> wr_ptr_gray_o=0 and level_o=0 asynchronously, before the next edge.
- 8 back-to-back writes with rd_ptr_gray_i=0 -> wr_ptr_gray_o sequence 1,3,2,6,7,5,4,C. full_o=1 after the 8th write. afull_o=1 once level_o>=6. Every step is a single-bit change.
- Full, then wr_v_i=1 for 2 cycles -> wr_en_o=0, pointer held at 0xC, ovf_o=1 and remains 1 after wr_v_i drops.
- Full, rd_ptr_gray_i set to 1 in the same cycle as wr_v_i=1 -> full_o=0, wr_en_o=1, wr_addr_o=0, level_o=8 again next cycle.
- Wrap: step rd_ptr_gray_i through 16 pointers while writing continuously -> wr_bin wraps 15->0, gray 8->0, level_o stays correct, no ovf_o.
- Force rd_ptr_gray_i so that rd_bin = wr_bin+1 (level_o=15) -> ptr_err_o=1, sticky until rst.
